edge_cross_responder: RTL and testbench

- Receiving end of the four-phase req/ack flag-crossing protocol.
- Synchronises an asynchronous level `req` from the sending clock domain into `bclk`.
- Accepts each request exactly once and returns `ack` to the sender.
- Queues accepted events as a pending count, drained through a valid/ready strobe interface by downstream logic (averager trigger, DMA kick, etc.).

---
 rtl/edge_cross_pkg.sv | 16 +
 rtl/sync_ff.sv | 21 ++
 rtl/edge_cross_responder.sv | 125 ++++++++++++
 tb/tb_edge_cross_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_cross_pkg.sv
// Shared types and limits for the req/ack flag-crossing responder.
package edge_cross_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } resp_state_t;

  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic N-stage single-bit synchroniser with async active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/edge_cross_responder.sv
// Receiving end of the four-phase req/ack crossing; queues accepted events as a pending count.
// Optional statistics counters are enabled by EDGE_CROSS_RESPONDER_STATS_EN.
module edge_cross_responder
  import edge_cross_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             bclk,
  input  logic             resetn,
  input  logic             req,
  output logic             ack,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic             tp
`ifdef EDGE_CROSS_RESPONDER_STATS_EN
  ,
  output logic [31:0]      evt_total,
  output logic [15:0]      drop_total
`endif
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("edge_cross_responder: SYNC_STAGES out of range");
  end

  logic        req_s;
  resp_state_t state_q, state_d;
  logic        accept;
  logic        ack_q;
  logic        tp_q;

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             inc, dec, sat, ovf_set;

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (bclk),
    .rst_n (resetn),
    .d     (req),
    .q     (req_s)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (req_s) begin
        accept  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (!req_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == S_HOLD);
      tp_q    <= accept;
    end
  end

  assign inc = accept;
  assign dec = evt_valid & evt_ready;
  assign sat = &pending_q;

  // A simultaneous take and accept leaves the count alone, even when saturated.
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (inc && !dec) begin
      if (sat) ovf_set   = 1'b1;
      else     pending_d = pending_q + CNT_W'(1);
    end else if (dec && !inc) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  assign overflow_d = ovf_set | (overflow_q & ~clr_overflow);

  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign ack       = ack_q;
  assign tp        = tp_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign evt_valid = |pending_q;

`ifdef EDGE_CROSS_RESPONDER_STATS_EN
  logic [31:0] evt_total_q;
  logic [15:0] drop_total_q;

  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      evt_total_q  <= '0;
      drop_total_q <= '0;
    end else begin
      evt_total_q <= evt_total_q + 32'(accept);
      if (ovf_set && (drop_total_q != 16'hFFFF)) drop_total_q <= drop_total_q + 16'd1;
    end
  end

  assign evt_total  = evt_total_q;
  assign drop_total = drop_total_q;
`endif

endmodule

// File: tb/tb_edge_cross_responder.sv
// Self-checking bench for edge_cross_responder: vector table plus directed handshake sequences.
module tb_edge_cross_responder;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int SAT         = (1 << CNT_W) - 1;

  logic             bclk = 1'b0;
  logic             resetn;
  logic             req;
  logic             ack;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             clr_overflow;
  logic             tp;
`ifdef EDGE_CROSS_RESPONDER_STATS_EN
  logic [31:0]      evt_total;
  logic [15:0]      drop_total;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int tp_cnt   = 0;

  always #5 bclk = ~bclk;

  always @(posedge bclk) if (tp === 1'b1) tp_cnt <= tp_cnt + 1;

  edge_cross_responder #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .bclk         (bclk),
    .resetn       (resetn),
    .req          (req),
    .ack          (ack),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tp           (tp)
`ifdef EDGE_CROSS_RESPONDER_STATS_EN
    ,
    .evt_total    (evt_total),
    .drop_total   (drop_total)
`endif
  );

  typedef enum {OP_HS, OP_DRAIN, OP_CLR} op_e;
  typedef struct {
    op_e op;
    int  arg;
    int  exp_pending;
    bit  exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge bclk);
    #1;
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ack !== v && n < 20) begin
      step();
      n++;
    end
    check(v ? "ack_rise_timeout" : "ack_fall_timeout", 32'(ack), 32'(v));
  endtask

  task automatic handshake();
    req = 1'b1;
    wait_ack(1'b1);
    req = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic do_reset();
    step();
    #1 resetn = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    step();
    step();
    resetn = 1'b1;
  endtask

  // Raise req and return in the cycle where accept is combinationally high.
  task automatic raise_to_accept();
    req = 1'b1;
    repeat (SYNC_STAGES) step();
  endtask

  vec_t vecs[8];

  initial begin
    int tp0;
    int ack_low;

    vecs[0] = '{OP_DRAIN, 4,  0,   1'b0};
    vecs[1] = '{OP_HS,    1,  1,   1'b0};
    vecs[2] = '{OP_HS,    13, 14,  1'b0};
    vecs[3] = '{OP_HS,    1,  SAT, 1'b0};
    vecs[4] = '{OP_HS,    1,  SAT, 1'b1};
    vecs[5] = '{OP_CLR,   1,  SAT, 1'b0};
    vecs[6] = '{OP_HS,    1,  SAT, 1'b1};
    vecs[7] = '{OP_CLR,   1,  SAT, 1'b0};

    resetn = 1'b0; req = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0;
    #1;
    check("por_ack", 32'(ack), 0);
    check("por_pending", 32'(pending), 0);
    check("por_tp", 32'(tp), 0);
    check("por_evt_valid", 32'(evt_valid), 0);
    step(); step();
    resetn = 1'b1;
    step();

    // Single handshake with exact latencies.
    tp0 = tp_cnt;
    raise_to_accept();
    check("acc_cycle_ack", 32'(ack), 0);
    check("acc_cycle_valid", 32'(evt_valid), 0);
    step();
    check("hs1_ack", 32'(ack), 1);
    check("hs1_pending", 32'(pending), 1);
    check("hs1_valid", 32'(evt_valid), 1);
    check("hs1_tp_high", 32'(tp), 1);
    step();
    check("hs1_tp_low", 32'(tp), 0);
    req = 1'b0;
    step(); step();
    check("hs1_ack_hold", 32'(ack), 1);
    step();
    check("hs1_ack_fall", 32'(ack), 0);
    check("hs1_tp_count", 32'(tp_cnt - tp0), 1);

    // Long request: one accept only, ack held throughout.
    tp0 = tp_cnt;
    req = 1'b1;
    wait_ack(1'b1);
    ack_low = 0;
    repeat (50) begin
      step();
      if (ack !== 1'b1) ack_low++;
    end
    check("long_ack_low_cycles", 32'(ack_low), 0);
    check("long_pending", 32'(pending), 2);
    req = 1'b0;
    wait_ack(1'b0);
    check("long_tp_count", 32'(tp_cnt - tp0), 1);

    // Counter saturation, overflow and clear.
    for (int i = 0; i < $size(vecs); i++) begin
      tp0 = tp_cnt;
      case (vecs[i].op)
        OP_HS: begin
          repeat (vecs[i].arg) handshake();
          check($sformatf("v%0d_tp_count", i), 32'(tp_cnt - tp0), 32'(vecs[i].arg));
        end
        OP_DRAIN: begin
          evt_ready = 1'b1;
          repeat (vecs[i].arg) step();
          evt_ready = 1'b0;
        end
        OP_CLR: begin
          clr_overflow = 1'b1;
          step();
          clr_overflow = 1'b0;
        end
        default: ;
      endcase
      step();
      check($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pending));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_pending != 0));
    end

    // Take and accept in the same cycle while saturated.
    raise_to_accept();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("incdec_pending", 32'(pending), SAT);
    check("incdec_overflow", 32'(overflow), 0);
    req = 1'b0;
    wait_ack(1'b0);

    // Saturated accept with clear in the same cycle: set wins.
    raise_to_accept();
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("setwins_overflow", 32'(overflow), 1);
    check("setwins_pending", 32'(pending), SAT);
    req = 1'b0;
    wait_ack(1'b0);

    evt_ready = 1'b1;
    repeat (SAT - 2) step();
    evt_ready = 1'b0;
    check("drain13_pending", 32'(pending), 2);
    check("drain13_overflow", 32'(overflow), 1);

    // Reset mid-handshake, req still high afterwards.
    req = 1'b1;
    wait_ack(1'b1);
    check("pre_rst_pending", 32'(pending), 3);
    do_reset();
    wait_ack(1'b1);
    check("post_rst_pending", 32'(pending), 1);
    req = 1'b0;
    wait_ack(1'b0);

    evt_ready = 1'b1;
    repeat (3) step();
    evt_ready = 1'b0;
    check("final_pending", 32'(pending), 0);
    check("final_valid", 32'(evt_valid), 0);

`ifdef EDGE_CROSS_RESPONDER_STATS_EN
    do_reset();
    step();
    repeat (20) handshake();
    step();
    check("stats_evt_total", evt_total, 20);
    check("stats_drop_total", 32'(drop_total), 5);
    check("stats_pending", 32'(pending), SAT);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
